// File: rtl/pwm_pkg.sv
// Shared definitions for the count-driven PWM block: FSM state encoding
// and default widths for the consumed count and the wrap counter.
package pwm_pkg;

    localparam int CNT_W_DEF  = 8;
    localparam int WRAP_W_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_RUN  = 2'd2
    } pwm_state_e;

endpackage

// File: rtl/count_step_det.sv
// Tracks the previous upstream count and flags a wrap (all-ones -> 0)
// or a legal step (hold or +1 modulo 2^CNT_W) on the current cycle.
module count_step_det
    import pwm_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [CNT_W-1:0] count,
    output logic             wrap,
    output logic             step_ok,
    output logic [CNT_W-1:0] prev_count
);

    logic [CNT_W-1:0] prev_count_q;
    logic [CNT_W-1:0] prev_count_d;

    always_comb begin
        prev_count_d = count;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_count_q <= '0;
        end else begin
            prev_count_q <= prev_count_d;
        end
    end

    // The +1 compare wraps naturally at CNT_W bits, so 255 -> 0 is also a legal step.
    always_comb begin
        wrap    = (prev_count_q == '1) && (count == '0);
        step_ok = (count == prev_count_q + CNT_W'(1)) || (count == prev_count_q);
    end

    assign prev_count = prev_count_q;

endmodule

// File: rtl/pwm_from_count.sv
// PWM generator slaved to a free-running upstream counter: arms on enable,
// runs from the first wrap, and resynchronises on any count discontinuity.
module pwm_from_count
    import pwm_pkg::*;
#(
    parameter int CNT_W  = CNT_W_DEF,
    parameter int WRAP_W = WRAP_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [CNT_W-1:0]  count,
    input  logic              enable,
    input  logic              duty_wr,
    input  logic [CNT_W-1:0]  duty_in,
    input  logic              irq_ack,
    output logic              pwm,
    output logic              period_done,
    output logic              irq,
    output logic              sync_err,
    output logic [CNT_W-1:0]  duty_active,
    output logic [WRAP_W-1:0] wrap_cnt
);

    function automatic logic [WRAP_W-1:0] sat_inc(input logic [WRAP_W-1:0] v);
        return (v == '1) ? v : v + WRAP_W'(1);
    endfunction

    logic             wrap;
    logic             step_ok;
    // The detector exports its history register for debug probing only.
    logic [CNT_W-1:0] prev_count_unused;

    count_step_det #(
        .CNT_W (CNT_W)
    ) u_det (
        .clk        (clk),
        .reset      (reset),
        .count      (count),
        .wrap       (wrap),
        .step_ok    (step_ok),
        .prev_count (prev_count_unused)
    );

    pwm_state_e        state_q,       state_d;
    logic [CNT_W-1:0]  shadow_q,      shadow_d;
    logic [CNT_W-1:0]  duty_active_q, duty_active_d;
    logic              pwm_q,         pwm_d;
    logic              period_done_q, period_done_d;
    logic              irq_q,         irq_d;
    logic              sync_err_q,    sync_err_d;
    logic [WRAP_W-1:0] wrap_cnt_q,    wrap_cnt_d;

    logic enter_run;
    logic discont;
    logic load_duty;

    always_comb begin
        state_d   = state_q;
        enter_run = 1'b0;
        discont   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d = ST_ARM;
                end
            end
            ST_ARM: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                end else if (wrap) begin
                    state_d   = ST_RUN;
                    enter_run = 1'b1;
                end
            end
            ST_RUN: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                end else if (!wrap && !step_ok) begin
                    state_d = ST_ARM;
                    discont = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // A write coinciding with the wrap reaches duty_active directly via shadow_d.
    always_comb begin
        load_duty     = enable && wrap && (state_q != ST_IDLE);
        shadow_d      = duty_wr ? duty_in : shadow_q;
        duty_active_d = load_duty ? shadow_d : duty_active_q;

        pwm_d         = (state_d == ST_RUN) && (count < duty_active_d);
        period_done_d = (state_q == ST_RUN) && enable && wrap;
        irq_d         = period_done_q || (irq_q && !irq_ack);

        wrap_cnt_d = wrap_cnt_q;
        if (enter_run) begin
            wrap_cnt_d = '0;
        end else if (period_done_d) begin
            wrap_cnt_d = sat_inc(wrap_cnt_q);
        end

        sync_err_d = sync_err_q;
        if ((state_d == ST_IDLE) && (state_q != ST_IDLE)) begin
            sync_err_d = 1'b0;
        end else if (discont) begin
            sync_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            shadow_q      <= '0;
            duty_active_q <= '0;
            pwm_q         <= 1'b0;
            period_done_q <= 1'b0;
            irq_q         <= 1'b0;
            sync_err_q    <= 1'b0;
            wrap_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            shadow_q      <= shadow_d;
            duty_active_q <= duty_active_d;
            pwm_q         <= pwm_d;
            period_done_q <= period_done_d;
            irq_q         <= irq_d;
            sync_err_q    <= sync_err_d;
            wrap_cnt_q    <= wrap_cnt_d;
        end
    end

    assign pwm         = pwm_q;
    assign period_done = period_done_q;
    assign irq         = irq_q;
    assign sync_err    = sync_err_q;
    assign duty_active = duty_active_q;
    assign wrap_cnt    = wrap_cnt_q;

endmodule

// File: doc/pwm_from_count.md
PWM_FROM_COUNT -- requirements
Module: pwm_from_count

Interface
REQ-001 Parameter CNT_W, default 8: width of the consumed count and of the duty value.
REQ-002 Parameter WRAP_W, default 16: width of the wrap counter.
REQ-003 clk  input  1  rising-edge clock, shared with the upstream 8-bit counter.
REQ-004 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 count  input  CNT_W  free-running count from the upstream counter, sampled every clk.
REQ-006 enable  input  1  block enable; 0 forces IDLE.
REQ-007 duty_wr  input  1  single-cycle strobe that writes duty_in into the shadow register.
REQ-008 duty_in  input  CNT_W  requested duty value.
REQ-009 irq_ack  input  1  clears irq.
REQ-010 pwm  output  1  registered PWM output.
REQ-011 period_done  output  1  one-cycle pulse on each detected wrap while in RUN.
REQ-012 irq  output  1  sticky period interrupt.
REQ-013 sync_err  output  1  sticky flag for a count discontinuity.
REQ-014 duty_active  output  CNT_W  duty value in use for the current period.
REQ-015 wrap_cnt  output  WRAP_W  number of wraps seen in RUN; saturating.

Function
REQ-016 The block SHALL register count into prev_count every cycle.
  - wrap = (prev_count == all-ones) and (count == 0).
  - step_ok = (count == prev_count + 1, modulo 2^CNT_W) or (count == prev_count).
REQ-017 The FSM SHALL have three states: IDLE, ARM and RUN.
  - IDLE -> ARM when enable = 1.
  - ARM -> RUN on the first wrap.
  - ARM or RUN -> IDLE whenever enable = 0.
REQ-018 duty_wr SHALL load the shadow register in any state.
REQ-019 On each wrap in ARM or RUN, duty_active SHALL load the shadow value.
  - If duty_wr is high in the same cycle, duty_in SHALL be loaded instead (the write wins).
REQ-020 In RUN, pwm SHALL be registered as (count < duty_active), giving one cycle of latency from count.
  - pwm SHALL be 0 in IDLE and ARM.
REQ-021 Duty boundaries:
  - duty_active = 0 SHALL give pwm constant 0.
  - duty_active = all-ones SHALL give pwm high for 255 of 256 counts.
REQ-022 period_done SHALL pulse for one cycle in the cycle after a wrap is detected in RUN.
  - The ARM -> RUN wrap SHALL NOT pulse.
REQ-023 irq SHALL set on period_done and clear on irq_ack.
  - If set and ack occur in the same cycle, set wins.
REQ-024 wrap_cnt SHALL increment on each period_done and hold at all-ones (no roll-over).
REQ-025 In RUN, a cycle with neither wrap nor step_ok SHALL set sync_err.
  - This covers an upstream synchronous reset mid-count or a skipped value.
  - sync_err SHALL clear only on entry to IDLE or on reset.
  - The FSM SHALL return to ARM in the same cycle.
REQ-026 Leaving RUN (enable = 0) SHALL drop pwm to 0 on the next clock.
  - duty_active and wrap_cnt SHALL retain their values until the next ARM -> RUN transition.
  - wrap_cnt SHALL clear on that transition.

Reset
REQ-027 While reset = 0, the block SHALL asynchronously force:
  - FSM = IDLE, prev_count = 0, shadow = 0, duty_active = 0;
  - pwm = 0, period_done = 0, irq = 0, sync_err = 0, wrap_cnt = 0.
REQ-028 Reset deassertion SHALL be sampled synchronously, so the first state change occurs on the first clk edge with reset = 1.
REQ-029 Reset asserted mid-period SHALL discard any pending shadow write and any in-flight period_done.

Structure
REQ-030 The FSM state encoding (IDLE/ARM/RUN) and the CNT_W/WRAP_W defaults SHALL live in a shared package pwm_pkg.
REQ-031 The wrap/step detector SHALL be a separate sub-module, count_step_det.
  - Inputs: clk, reset, count.
  - Outputs: wrap, step_ok, prev_count.
REQ-032 All other logic SHALL be single-clock-domain in pwm_from_count.

Verification
REQ-033 The bench SHALL pair the block with the upstream 8-bit counter driving count, clock period 100 units, and cover:
REQ-034 Basic duty: reset low for 2 clk, enable = 1, write duty 64 -> first wrap enters RUN; each later period gives pwm high 64 clk and low 192 clk; period_done every 256 clk.
REQ-035 Duty update: duty_wr 200 at count 10 of a period -> current period stays at 64; next period high 200 clk. A write coinciding with the wrap cycle takes effect in that same new period.
REQ-036 Boundaries: duty 0 -> pwm never high; duty 255 -> exactly one low clk per period.
REQ-037 Interrupt: irq_ack held high on the period_done cycle -> irq stays 1; ack one cycle later -> irq = 0.
REQ-038 Discontinuity: pulse the upstream counter reset at count 37 -> sync_err = 1, FSM back to ARM, pwm = 0 until the next wrap.
REQ-039 Async reset: reset low mid-period (between clock edges) -> all outputs 0 immediately; wrap_cnt = 0.
